// File: rtl/dflow_pkg.sv
// dflow_pkg: shared replay state type, default memory geometry and counter sizing helper
package dflow_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} replay_state_t;
   localparam int DFLOW_MEM_ADDR_WIDTH = 19;
   localparam int DFLOW_MEM_DATA_WIDTH = 144;
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/dflow_sync_fifo.sv
// dflow_sync_fifo: first-word-fall-through buffer with an occupancy count for credit tracking
module dflow_sync_fifo
   import dflow_pkg::*;
#(
   parameter int WIDTH = DFLOW_MEM_DATA_WIDTH,
   parameter int DEPTH = 16,
   parameter int CW    = cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic [CW-1:0]    count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic full, do_pop, do_push;
   assign empty   = count == '0;
   assign full    = count == CW'(DEPTH);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rp];
   always_ff @(posedge clk) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         wp    <= wp + AW'(do_push);
         rp    <= rp + AW'(do_pop);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
   always_ff @(posedge clk) if (do_push) mem[wp] <= din;
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push & full & ~do_pop));
endmodule

// File: rtl/dflow_mem_replay.sv
// dflow_mem_replay: replays stored 5-tuple entries from memory onto a credit-limited valid/ready stream.
// Define DFLOW_REPLAY_STATS_EN to add the stat_words/stat_stall/stat_starve counters.
module dflow_mem_replay
   import dflow_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = DFLOW_MEM_ADDR_WIDTH,
   parameter int MEM_DATA_WIDTH = DFLOW_MEM_DATA_WIDTH,
   parameter int BUF_DEPTH      = 16,
   parameter int LOOP_WIDTH     = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      sw_rst,
   input  logic                      cal_done,
   input  logic                      start_replay,
   input  logic [LOOP_WIDTH-1:0]     loop_count,
   input  logic [MEM_ADDR_WIDTH-1:0] dflow_addr_low,
   input  logic [MEM_ADDR_WIDTH-1:0] dflow_mem_high,
   output logic                      app_rd_cmd,
   output logic [MEM_ADDR_WIDTH-1:0] app_rd_addr,
   input  logic                      app_rd_valid,
   input  logic [MEM_DATA_WIDTH-1:0] app_rd_data,
   output logic                      out_valid,
   output logic [MEM_DATA_WIDTH-1:0] out_data,
   input  logic                      out_ready,
   output logic                      busy,
`ifdef DFLOW_REPLAY_STATS_EN
   output logic [31:0]               stat_words,
   output logic [31:0]               stat_stall,
   output logic [31:0]               stat_starve,
`endif
   output logic                      done
);
   localparam int CW = cnt_w(BUF_DEPTH);
   localparam int SW = CW + 1;
   replay_state_t state, state_nx;
   logic rst, range_ok, launch, credit, issue, wrap, last, accept, drained, hold, buf_empty;
   logic [MEM_ADDR_WIDTH-1:0] addr, low_q, high_q;
   logic [LOOP_WIDTH-1:0] loops_q, passes;
   logic [CW-1:0] outstanding, buf_count;
   assign rst      = ~rst_n | sw_rst;
   assign range_ok = dflow_mem_high > dflow_addr_low;
   assign launch   = (state == IDLE) & start_replay & cal_done & range_ok & ~hold;
   // Reads in flight plus buffered words may never exceed the buffer, whatever the read latency.
   assign credit   = SW'(outstanding) + SW'(buf_count) < SW'(BUF_DEPTH);
   assign issue    = (state == ISSUE) & start_replay & cal_done & credit & ~rst;
   assign wrap     = addr == high_q - MEM_ADDR_WIDTH'(1);
   assign last     = wrap & (loops_q != '0) & ((passes + LOOP_WIDTH'(1)) == loops_q);
   assign accept   = app_rd_valid & (state != IDLE) & (outstanding != '0);
   assign drained  = (outstanding == '0) & (buf_count == '0);
   assign busy        = state != IDLE;
   assign app_rd_cmd  = issue;
   assign app_rd_addr = addr;
   assign out_valid   = ~buf_empty;
   // hold keeps a finished or empty-range run from retriggering until start_replay is released.
   assign done = ~rst & ((state == DRAIN) ? drained : (state == IDLE) & start_replay & ~range_ok & ~hold);
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = launch ? ISSUE : IDLE;
         ISSUE:   state_nx = ((issue & last) | ~start_replay) ? DRAIN : ISSUE;
         DRAIN:   state_nx = drained ? IDLE : DRAIN;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         addr        <= '0;
         low_q       <= '0;
         high_q      <= '0;
         loops_q     <= '0;
         passes      <= '0;
         outstanding <= '0;
         hold        <= 1'b0;
      end else begin
         state       <= state_nx;
         outstanding <= outstanding + CW'(issue) - CW'(accept);
         hold        <= start_replay & (hold | done);
         if (launch) begin
            addr    <= dflow_addr_low;
            low_q   <= dflow_addr_low;
            high_q  <= dflow_mem_high;
            loops_q <= loop_count;
            passes  <= '0;
         end else if (issue) begin
            addr   <= wrap ? low_q : addr + MEM_ADDR_WIDTH'(1);
            passes <= passes + LOOP_WIDTH'(wrap);
         end
      end
   end
   dflow_sync_fifo #(.WIDTH(MEM_DATA_WIDTH), .DEPTH(BUF_DEPTH)) u_buf (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .din   (app_rd_data),
      .pop   (out_ready),
      .dout  (out_data),
      .empty (buf_empty),
      .count (buf_count)
   );
   a_credit: assert property (@(posedge clk) disable iff (rst)
      SW'(outstanding) + SW'(buf_count) <= SW'(BUF_DEPTH));
`ifdef DFLOW_REPLAY_STATS_EN
   always_ff @(posedge clk) begin
      if (rst | launch) begin
         stat_words  <= '0;
         stat_stall  <= '0;
         stat_starve <= '0;
      end else begin
         stat_words  <= stat_words + 32'(out_valid & out_ready);
         stat_stall  <= stat_stall + 32'(out_valid & ~out_ready);
         stat_starve <= stat_starve + 32'((state == ISSUE) & ~credit);
      end
   end
`endif
endmodule

// File: tb/tb_dflow_mem_replay.sv
// tb_dflow_mem_replay: scoreboard bench with a latency-modelling memory responder and random stream backpressure
module tb_dflow_mem_replay;
   localparam int AW    = 19;
   localparam int DW    = 144;
   localparam int DEPTH = 16;
   localparam int LW    = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0, sw_rst = 1'b0, cal_done = 1'b0, start_replay = 1'b0;
   logic [LW-1:0] loop_count = '0;
   logic [AW-1:0] dflow_addr_low = '0, dflow_mem_high = '0;
   logic          app_rd_cmd;
   logic [AW-1:0] app_rd_addr;
   logic          app_rd_valid = 1'b0;
   logic [DW-1:0] app_rd_data = '0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready = 1'b0;
   logic          busy, done;

   always #5 clk = ~clk;

   dflow_mem_replay dut (
      .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst), .cal_done(cal_done), .start_replay(start_replay),
      .loop_count(loop_count), .dflow_addr_low(dflow_addr_low), .dflow_mem_high(dflow_mem_high),
      .app_rd_cmd(app_rd_cmd), .app_rd_addr(app_rd_addr), .app_rd_valid(app_rd_valid),
      .app_rd_data(app_rd_data), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   int errors = 0, checks = 0, cyc = 0;
   int exp_low = 0, exp_n = 1, k = 0, issues = 0, pops = 0, words = 0, seq = 0, done_cnt = 0;
   int lat_min = 1, lat_max = 1, last_due = 0, first_v = -1, first_o = -1, due = 0, d0 = 0;
   bit rand_ready = 1'b0, rand_cal = 1'b0, ready_lvl = 1'b1, late = 1'b0;
   logic [DW-1:0] sb[$], rdat_q[$];
   logic [DW-1:0] md, ed;
   int due_q[$];

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Memory contents tagged with a read sequence number so lost or duplicated words never alias.
   function automatic logic [DW-1:0] mdata(input int a, input int s);
      return {16'(s), 32'(a) * 32'h9E3779B1, 32'(a) ^ 32'h5A5A5A5A, 32'(a), ~32'(a)};
   endfunction

   always @(posedge clk) cyc++;

   // Read command monitor: expected address is low + (k mod n); expected stream word is pushed here.
   always @(negedge clk) begin
      if (app_rd_cmd) begin
         chk("rd_addr", longint'(app_rd_addr), exp_n > 0 ? longint'(exp_low + k % exp_n) : -1);
         md = mdata(int'(app_rd_addr), seq);
         seq++;
         k++;
         issues++;
         sb.push_back(md);
         due = cyc + int'($urandom_range(lat_max, lat_min));
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         due_q.push_back(due);
         rdat_q.push_back(md);
      end
   end

   // Stream monitor and credit invariant: reads issued but not yet streamed never exceed the buffer.
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (out_valid && first_o < 0) first_o = cyc;
      if (out_valid && out_ready) begin
         pops++;
         words++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL stream_extra: got %h expected no word", out_data);
         end else begin
            ed = sb.pop_front();
            if (out_data !== ed) begin
               errors++;
               $display("FAIL stream_data: got %h expected %h", out_data, ed);
            end
         end
      end
      if (busy) chk("credit_inv", longint'(issues - pops <= DEPTH), 1);
   end

   // Memory responder and randomised inputs, driven just after the active edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (due_q.size() > 0 && due_q[0] <= cyc) begin
            app_rd_valid = 1'b1;
            app_rd_data  = rdat_q.pop_front();
            void'(due_q.pop_front());
            if (first_v < 0) first_v = cyc;
         end else begin
            app_rd_valid = 1'b0;
         end
         out_ready = rand_ready ? ($urandom_range(1, 0) == 1) : ready_lvl;
         if (rand_cal) cal_done = $urandom_range(3, 0) != 0;
      end
   end

   task automatic start_run(input int lo, input int hi, input int loops);
      dflow_addr_low = AW'(lo);
      dflow_mem_high = AW'(hi);
      loop_count     = LW'(loops);
      exp_low = lo;
      exp_n   = hi - lo;
      k = 0;
      issues = 0;
      pops = 0;
      words = 0;
      start_replay = 1'b1;
   endtask

   task automatic wait_done(input string nm, input int budget);
      int d = done_cnt;
      for (int i = 0; i < budget && done_cnt == d; i++) step(1);
      chk(nm, done_cnt - d, 1);
   endtask

   task automatic run_random(input int lo, input int n, input int nw);
      lat_min = 1;
      lat_max = 12;
      rand_ready = 1'b1;
      rand_cal = 1'b1;
      start_run(lo, lo + n, 0);
      for (int i = 0; i < 30000 && words < nw; i++) step(1);
      chk("rand_words_reached", longint'(words >= nw), 1);
      start_replay = 1'b0;
      rand_cal = 1'b0;
      cal_done = 1'b1;
      wait_done("rand_done", 1000);
      chk("rand_idle", busy, 0);
      chk("rand_no_loss", words, issues);
      chk("rand_sb_empty", sb.size(), 0);
      rand_ready = 1'b0;
      ready_lvl = 1'b1;
      step(20);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      step(3);
      chk("rst_rd_cmd", app_rd_cmd, 0);
      chk("rst_rd_addr", app_rd_addr, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data_zero", longint'(out_data == '0), 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst_n = 1'b1;
      cal_done = 1'b1;
      step(2);

      // Two passes over 0x10..0x13, fixed latency 5, always ready.
      lat_min = 5;
      lat_max = 5;
      first_v = -1;
      first_o = -1;
      d0 = done_cnt;
      start_run(32'h10, 32'h14, 2);
      wait_done("t1_done", 200);
      start_replay = 1'b0;
      chk("t1_busy_low", busy, 0);
      chk("t1_reads", issues, 8);
      chk("t1_words", words, 8);
      chk("t1_latency", first_o - first_v, 1);
      step(5);
      chk("t1_done_once", done_cnt - d0, 1);

      // Stream blocked: issue must stop at the credit limit and resume on release.
      lat_min = 3;
      lat_max = 3;
      ready_lvl = 1'b0;
      step(2);
      start_run(32'h100, 32'h105, 0);
      step(60);
      chk("t2_credit_stall", issues, 16);
      chk("t2_valid_held", out_valid, 1);
      ready_lvl = 1'b1;
      step(40);
      chk("t2_resumed", longint'(issues > 16), 1);
      start_replay = 1'b0;
      wait_done("t2_done", 300);
      chk("t2_no_loss", words, issues);
      chk("t2_sb_empty", sb.size(), 0);
      step(5);

      // Empty range pulses done once; missing calibration keeps the block idle.
      d0 = done_cnt;
      start_run(32'h50, 32'h50, 0);
      step(20);
      chk("t6_empty_no_reads", issues, 0);
      chk("t6_empty_done_once", done_cnt - d0, 1);
      chk("t6_empty_idle", busy, 0);
      start_replay = 1'b0;
      step(2);
      cal_done = 1'b0;
      start_run(32'h60, 32'h64, 1);
      step(20);
      chk("t6_nocal_idle", busy, 0);
      chk("t6_nocal_reads", issues, 0);
      cal_done = 1'b1;
      wait_done("t6_cal_done", 100);
      chk("t6_cal_reads", issues, 4);
      chk("t6_cal_words", words, 4);
      start_replay = 1'b0;
      step(5);

      // Graceful stop with five reads in flight.
      lat_min = 10;
      lat_max = 10;
      start_run(32'h200, 32'h240, 0);
      for (int i = 0; i < 50 && issues < 5; i++) step(1);
      start_replay = 1'b0;
      wait_done("t4_done", 200);
      chk("t4_reads", issues, 5);
      chk("t4_words", words, 5);
      chk("t4_idle", busy, 0);
      chk("t4_sb_empty", sb.size(), 0);
      step(5);

      // Software reset with reads in flight; late returns must be ignored.
      lat_min = 8;
      lat_max = 8;
      start_run(32'h300, 32'h310, 0);
      for (int i = 0; i < 50 && issues < 6; i++) step(1);
      sw_rst = 1'b1;
      start_replay = 1'b0;
      step(1);
      sb.delete();
      issues = 0;
      pops = 0;
      chk("t5_rd_cmd", app_rd_cmd, 0);
      chk("t5_rd_addr", app_rd_addr, 0);
      chk("t5_out_valid", out_valid, 0);
      chk("t5_out_data_zero", longint'(out_data == '0), 1);
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      sw_rst = 1'b0;
      late = 1'b0;
      for (int i = 0; i < 25; i++) begin
         step(1);
         if (out_valid || busy) late = 1'b1;
      end
      chk("t5_late_ignored", late, 0);
      step(10);

      run_random(int'($urandom_range(4000, 0)), int'($urandom_range(40, 2)), 1000);
      run_random(int'($urandom_range(4000, 0)), 1, 200);
      run_random(32'h7FFF0, 15, 300);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
